// File: rtl/block_mem_responder.sv
// block_mem_responder: block-oriented memory responder for a cache refill/write-back port.
// Storage is 64 blocks of four 32-bit words. Each request spends LATENCY cycles in ACCESS
// before a response is presented. The response is held until the cache consumes it.
// Optional build macro MEM_STATS_EN adds saturating read/write acceptance counters.

module block_mem_responder #(
  parameter int LATENCY = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  input  logic         req_write,
  input  logic [9:0]   req_addr,
  input  logic [127:0] req_wdata,
  output logic         req_ready,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [127:0] resp_rdata
`ifdef MEM_STATS_EN
  ,
  output logic [15:0]  rd_count,
  output logic [15:0]  wr_count
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t       state;
  logic [3:0]   count;
  logic         cap_write;
  logic [5:0]   cap_block;
  logic [127:0] cap_wdata;
  logic         commit;
  logic [31:0]  mem_q [256];
  logic [127:0] rd_block;

  // The low address bits only select a byte inside the block and play no part here.
  logic         unused_addr_bits;
  assign unused_addr_bits = ^req_addr[3:0];

  // A captured write lands in storage on the final ACCESS edge. Reset on the same
  // edge wins, so an aborted write never reaches storage.
  assign commit = (state == ACCESS) && (count == 4'd1) && cap_write && !reset;

  // Each storage word gets its own register. The power-up value of word w is w.
  // Reset deliberately leaves storage alone.
  for (genvar i = 0; i < 256; i++) begin : g_word
    logic [31:0] word = 32'(i);

    // Update this word when the committing block covers it
    always_ff @(posedge clk) begin
      if (commit && (cap_block == 6'(i / 4))) begin
        word <= cap_wdata[32*(i%4) +: 32];
      end
    end

    assign mem_q[i] = word;
  end

  assign rd_block = {mem_q[{cap_block, 2'd3}], mem_q[{cap_block, 2'd2}],
                     mem_q[{cap_block, 2'd1}], mem_q[{cap_block, 2'd0}]};

  // Request/response sequencing with registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      cap_write  <= 1'b0;
      cap_block  <= 6'd0;
      cap_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            cap_write <= req_write;
            cap_block <= req_addr[9:4];
            cap_wdata <= req_wdata;
            count     <= 4'(LATENCY);
            req_ready <= 1'b0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (count == 4'd1) begin
            count      <= 4'd0;
            resp_valid <= 1'b1;
            resp_rdata <= cap_write ? cap_wdata : rd_block;
            state      <= RESP;
          end else begin
            count <= count - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef MEM_STATS_EN
  logic accept;
  assign accept = (state == IDLE) && req_valid && req_ready;

  // Count accepted reads and writes separately, sticking at the top value
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else if (accept) begin
      if (req_write) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_block_mem_responder.sv
// tb_block_mem_responder: scoreboard bench for block_mem_responder.
// The main instance uses the default latency. A second instance with LATENCY = 1
// exercises back-to-back throughput. Build with MEM_STATS_EN to also cover the counters.

module tb_block_mem_responder;

  logic         clk;
  logic         reset;
  logic         req_valid;
  logic         req_write;
  logic [9:0]   req_addr;
  logic [127:0] req_wdata;
  logic         req_ready;
  logic         resp_valid;
  logic         resp_ready;
  logic [127:0] resp_rdata;

  logic         fast_req_valid;
  logic         fast_req_write;
  logic [9:0]   fast_req_addr;
  logic [127:0] fast_req_wdata;
  logic         fast_req_ready;
  logic         fast_resp_valid;
  logic         fast_resp_ready;
  logic [127:0] fast_resp_rdata;

`ifdef MEM_STATS_EN
  logic [15:0]  rd_count;
  logic [15:0]  wr_count;
  logic [15:0]  fast_rd_count;
  logic [15:0]  fast_wr_count;
`endif

  int checks;
  int passed;

  logic [31:0]  model [256];
  logic [127:0] exp_q [$];
  logic [127:0] fast_q [$];

  block_mem_responder #(.LATENCY(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata)
`ifdef MEM_STATS_EN
    ,
    .rd_count   (rd_count),
    .wr_count   (wr_count)
`endif
  );

  block_mem_responder #(.LATENCY(1)) fast_dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (fast_req_valid),
    .req_write  (fast_req_write),
    .req_addr   (fast_req_addr),
    .req_wdata  (fast_req_wdata),
    .req_ready  (fast_req_ready),
    .resp_valid (fast_resp_valid),
    .resp_ready (fast_resp_ready),
    .resp_rdata (fast_resp_rdata)
`ifdef MEM_STATS_EN
    ,
    .rd_count   (fast_rd_count),
    .wr_count   (fast_wr_count)
`endif
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] model_block(input logic [5:0] b);
    return {model[{b, 2'd3}], model[{b, 2'd2}], model[{b, 2'd1}], model[{b, 2'd0}]};
  endfunction

  function automatic logic [127:0] init_block(input logic [5:0] b);
    logic [7:0] base;
    base = {b, 2'd0};
    return {24'd0, base + 8'd3, 24'd0, base + 8'd2, 24'd0, base + 8'd1, 24'd0, base};
  endfunction

  // Record what the main instance should answer for an accepted request
  task automatic push_expect(input logic w, input logic [9:0] a, input logic [127:0] d);
    if (w) begin
      for (int k = 0; k < 4; k++) model[{a[9:4], 2'(k)}] = d[32*k +: 32];
      exp_q.push_back(d);
    end else begin
      exp_q.push_back(model_block(a[9:4]));
    end
  endtask

  task automatic pop_expect(output logic [127:0] e);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 'x;
  endtask

  // Present a request for exactly one edge; the caller guarantees req_ready
  task automatic send(input logic w, input logic [9:0] a, input logic [127:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    tick();
    req_valid = 1'b0;
    req_write = 1'b0;
    req_wdata = '0;
  endtask

  task automatic wait_resp(output int cycles);
    cycles = 0;
    while (!resp_valid && cycles < 40) begin
      tick();
      cycles++;
    end
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (req_ready !== 1'b1) $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready);
    else passed++;
    checks++;
    if (resp_valid !== 1'b0) $display("[TB] FAIL reset_resp_valid: got %b expected 0", resp_valid);
    else passed++;
    checks++;
    if (resp_rdata !== 128'd0) $display("[TB] FAIL reset_resp_rdata: got %h expected 0", resp_rdata);
    else passed++;
  endtask

  task automatic test_read_latency();
    int cyc;
    logic [127:0] e;
    push_expect(1'b0, 10'h010, '0);
    send(1'b0, 10'h010, '0);
    checks++;
    if (req_ready !== 1'b0) $display("[TB] FAIL busy_after_accept: got %b expected 0", req_ready);
    else passed++;
    wait_resp(cyc);
    checks++;
    if (cyc !== 4) $display("[TB] FAIL read_latency: got %0d expected 4", cyc);
    else passed++;
    pop_expect(e);
    checks++;
    if (resp_rdata !== e) $display("[TB] FAIL read_data: got %h expected %h", resp_rdata, e);
    else passed++;
    checks++;
    if (resp_rdata !== {32'h7, 32'h6, 32'h5, 32'h4})
      $display("[TB] FAIL read_data_init: got %h expected %h", resp_rdata, {32'h7, 32'h6, 32'h5, 32'h4});
    else passed++;
    checks++;
    if (req_ready !== 1'b0) $display("[TB] FAIL busy_in_resp: got %b expected 0", req_ready);
    else passed++;
    finish_resp();
    checks++;
    if (resp_valid !== 1'b0) $display("[TB] FAIL resp_drop: got %b expected 0", resp_valid);
    else passed++;
    checks++;
    if (req_ready !== 1'b1) $display("[TB] FAIL ready_after_handshake: got %b expected 1", req_ready);
    else passed++;
  endtask

  task automatic test_write_read();
    int cyc;
    logic [127:0] e;
    logic [127:0] wd;
    wd = {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA};
    push_expect(1'b1, 10'h3F0, wd);
    send(1'b1, 10'h3F0, wd);
    wait_resp(cyc);
    checks++;
    if (cyc !== 4) $display("[TB] FAIL write_latency: got %0d expected 4", cyc);
    else passed++;
    pop_expect(e);
    checks++;
    if (resp_rdata !== e) $display("[TB] FAIL write_ack_data: got %h expected %h", resp_rdata, e);
    else passed++;
    finish_resp();
    push_expect(1'b0, 10'h3FC, '0);
    send(1'b0, 10'h3FC, '0);
    wait_resp(cyc);
    pop_expect(e);
    checks++;
    if (resp_rdata !== e) $display("[TB] FAIL read_after_write: got %h expected %h", resp_rdata, e);
    else passed++;
    checks++;
    if (resp_rdata !== wd) $display("[TB] FAIL read_after_write_const: got %h expected %h", resp_rdata, wd);
    else passed++;
    finish_resp();
  endtask

  task automatic test_stall();
    int cyc;
    logic [127:0] e;
    logic [127:0] held;
    logic valid_ok;
    logic stable_ok;
    logic ready_low;
    push_expect(1'b0, 10'h123, '0);
    send(1'b0, 10'h123, '0);
    wait_resp(cyc);
    checks++;
    if (cyc !== 4) $display("[TB] FAIL stall_latency: got %0d expected 4", cyc);
    else passed++;
    held      = resp_rdata;
    valid_ok  = 1'b1;
    stable_ok = 1'b1;
    ready_low = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 10'h200;
    req_wdata = {4{32'hDEADBEEF}};
    repeat (10) begin
      tick();
      if (resp_valid !== 1'b1) valid_ok = 1'b0;
      if (resp_rdata !== held) stable_ok = 1'b0;
      if (req_ready !== 1'b0) ready_low = 1'b0;
    end
    req_valid = 1'b0;
    req_write = 1'b0;
    req_wdata = '0;
    checks++;
    if (valid_ok !== 1'b1) $display("[TB] FAIL stall_valid_held: got %b expected 1", valid_ok);
    else passed++;
    checks++;
    if (stable_ok !== 1'b1) $display("[TB] FAIL stall_data_stable: got %b expected 1", stable_ok);
    else passed++;
    checks++;
    if (ready_low !== 1'b1) $display("[TB] FAIL stall_ready_low: got %b expected 1", ready_low);
    else passed++;
    pop_expect(e);
    checks++;
    if (resp_rdata !== e) $display("[TB] FAIL stall_data: got %h expected %h", resp_rdata, e);
    else passed++;
    finish_resp();
    push_expect(1'b0, 10'h200, '0);
    send(1'b0, 10'h200, '0);
    wait_resp(cyc);
    pop_expect(e);
    checks++;
    if (resp_rdata !== e) $display("[TB] FAIL ignored_request: got %h expected %h", resp_rdata, e);
    else passed++;
    finish_resp();
  endtask

  task automatic test_reset_abort();
    int cyc;
    logic [127:0] e;
    send(1'b1, 10'h020, {4{32'h12345678}});
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (req_ready !== 1'b1) $display("[TB] FAIL abort_idle_ready: got %b expected 1", req_ready);
    else passed++;
    checks++;
    if (resp_valid !== 1'b0) $display("[TB] FAIL abort_no_resp: got %b expected 0", resp_valid);
    else passed++;
    push_expect(1'b0, 10'h020, '0);
    send(1'b0, 10'h020, '0);
    wait_resp(cyc);
    pop_expect(e);
    checks++;
    if (resp_rdata !== e) $display("[TB] FAIL abort_storage: got %h expected %h", resp_rdata, e);
    else passed++;
    checks++;
    if (resp_rdata !== {32'hB, 32'hA, 32'h9, 32'h8})
      $display("[TB] FAIL abort_storage_const: got %h expected %h", resp_rdata, {32'hB, 32'hA, 32'h9, 32'h8});
    else passed++;
    finish_resp();
  endtask

  task automatic test_back_to_back();
    logic [9:0] addrs [4];
    logic [127:0] e;
    logic acc;
    int cyc;
    int acc_cyc;
    int last_resp;
    int n_acc;
    int n_resp;
    int low_run;
    addrs[0] = 10'h050;
    addrs[1] = 10'h0A4;
    addrs[2] = 10'h3C8;
    addrs[3] = 10'h10F;
    cyc       = 0;
    acc_cyc   = -100;
    last_resp = -1;
    n_acc     = 0;
    n_resp    = 0;
    low_run   = 0;
    fast_resp_ready = 1'b1;
    fast_req_addr   = addrs[0];
    fast_req_valid  = 1'b1;
    while (n_resp < 4 && cyc < 60) begin
      acc = fast_req_valid && fast_req_ready;
      if (acc) fast_q.push_back(init_block(fast_req_addr[9:4]));
      tick();
      cyc++;
      if (acc) begin
        acc_cyc = cyc;
        n_acc++;
        if (n_acc < 4) fast_req_addr = addrs[n_acc];
        else fast_req_valid = 1'b0;
      end
      if (fast_req_ready === 1'b0) begin
        low_run++;
      end else begin
        if (low_run > 0) begin
          checks++;
          if (low_run !== 2) $display("[TB] FAIL b2b_ready_low_run: got %0d expected 2", low_run);
          else passed++;
        end
        low_run = 0;
      end
      if (fast_resp_valid === 1'b1) begin
        n_resp++;
        checks++;
        if (cyc - acc_cyc !== 1) $display("[TB] FAIL b2b_latency: got %0d expected 1", cyc - acc_cyc);
        else passed++;
        if (last_resp >= 0) begin
          checks++;
          if (cyc - last_resp !== 3) $display("[TB] FAIL b2b_interval: got %0d expected 3", cyc - last_resp);
          else passed++;
        end
        if (fast_q.size() > 0) e = fast_q.pop_front();
        else e = 'x;
        checks++;
        if (fast_resp_rdata !== e) $display("[TB] FAIL b2b_data: got %h expected %h", fast_resp_rdata, e);
        else passed++;
        last_resp = cyc;
      end
    end
    fast_req_valid = 1'b0;
    checks++;
    if (n_resp !== 4) $display("[TB] FAIL b2b_response_count: got %0d expected 4", n_resp);
    else passed++;
  endtask

`ifdef MEM_STATS_EN
  task automatic test_stats();
    int cyc;
    logic [127:0] e;
    logic [9:0] addrs [5];
    logic writes [5];
    addrs[0] = 10'h030; writes[0] = 1'b0;
    addrs[1] = 10'h040; writes[1] = 1'b1;
    addrs[2] = 10'h040; writes[2] = 1'b0;
    addrs[3] = 10'h0F0; writes[3] = 1'b1;
    addrs[4] = 10'h0F0; writes[4] = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push_expect(writes[i], addrs[i], {4{32'(i) + 32'h5A00}});
      send(writes[i], addrs[i], {4{32'(i) + 32'h5A00}});
      wait_resp(cyc);
      pop_expect(e);
      checks++;
      if (resp_rdata !== e) $display("[TB] FAIL stats_data: got %h expected %h", resp_rdata, e);
      else passed++;
      finish_resp();
    end
    checks++;
    if (rd_count !== 16'd3) $display("[TB] FAIL stats_rd_count: got %0d expected 3", rd_count);
    else passed++;
    checks++;
    if (wr_count !== 16'd2) $display("[TB] FAIL stats_wr_count: got %0d expected 2", wr_count);
    else passed++;
    do_reset();
    checks++;
    if (rd_count !== 16'd0) $display("[TB] FAIL stats_rd_reset: got %0d expected 0", rd_count);
    else passed++;
    checks++;
    if (wr_count !== 16'd0) $display("[TB] FAIL stats_wr_reset: got %0d expected 0", wr_count);
    else passed++;
  endtask
`endif

  // Run every scenario in order, then report
  initial begin
    checks          = 0;
    passed          = 0;
    reset           = 1'b1;
    req_valid       = 1'b0;
    req_write       = 1'b0;
    req_addr        = '0;
    req_wdata       = '0;
    resp_ready      = 1'b0;
    fast_req_valid  = 1'b0;
    fast_req_write  = 1'b0;
    fast_req_addr   = '0;
    fast_req_wdata  = '0;
    fast_resp_ready = 1'b0;
    for (int w = 0; w < 256; w++) model[w] = 32'(w);
    $display("[TB] starting block_mem_responder bench");
    test_reset();
    test_read_latency();
    test_write_read();
    test_stall();
    test_reset_abort();
    test_back_to_back();
`ifdef MEM_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
